// File: rtl/body_pkg.sv
// Shared types and command-word layout for the body attribute table.
// Holds body_entry_t, field positions, COMMIT_INDEX and a word decoder.
package body_pkg;

  localparam int NUM_BODIES = 15;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [3:0]     radius;
    logic [3:0]     colour;
  } body_entry_t;

  localparam int TOG_BIT = 31;
  localparam int IDX_HI  = 30;
  localparam int IDX_LO  = 27;
  localparam int Y_HI    = 26;
  localparam int Y_LO    = 18;
  localparam int X_HI    = 17;
  localparam int X_LO    = 8;
  localparam int R_HI    = 7;
  localparam int R_LO    = 4;
  localparam int C_HI    = 3;
  localparam int C_LO    = 0;

  localparam logic [3:0] COMMIT_INDEX = 4'hF;

  function automatic body_entry_t decode_entry(
    input logic [31:0] w
  );
    body_entry_t e;
    e.x      = w[X_HI:X_LO];
    e.y      = w[Y_HI:Y_LO];
    e.radius = w[R_HI:R_LO];
    e.colour = w[C_HI:C_LO];
    return e;
  endfunction

endpackage

// File: rtl/body_bank.sv
// One bank of body entries: single write port, registered read port.
// Ports: clk/rst_n, we/waddr/wdata write, raddr in, rdata out (0 if raddr>=15).
module body_bank
  import body_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  body_entry_t wdata,
  input  logic [3:0]  raddr,
  output body_entry_t rdata
);

  body_entry_t mem [NUM_BODIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BODIES; i++)
        mem[i] <= '0;
      rdata <= '0;
    end else begin
      for (int i = 0; i < NUM_BODIES; i++)
        if (we && waddr == 4'(i))
          mem[i] <= wdata;
      if (raddr < 4'(NUM_BODIES))
        rdata <= mem[raddr];
      else
        rdata <= '0;
    end
  end

endmodule

// File: rtl/body_table.sv
// Double-buffered body table fed by the Nios command conduit.
// Ports: clk_clk, reset_reset_n, cmd_word, frame_start, rd_index -> rd_*, flags.
module body_table
  import body_pkg::*;
(
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  input  logic [31:0]    cmd_word,
  input  logic           frame_start,
  input  logic [3:0]     rd_index,
  output logic [X_W-1:0] rd_x,
  output logic [Y_W-1:0] rd_y,
  output logic [3:0]     rd_radius,
  output logic [3:0]     rd_colour,
  output logic           rd_valid,
  output logic           commit_pending,
  output logic           overflow
);

  logic [31:0] cmd_q;
  logic        tog_ref;
  logic        front_sel;
  logic        sel_q;
  logic        pend_q;
  logic        ovf_q;

  logic        accept;
  logic        is_commit;
  logic        wr_body;
  logic        swap;
  logic [3:0]  cmd_idx;
  body_entry_t cmd_entry;
  body_entry_t rd0;
  body_entry_t rd1;
  body_entry_t rd_e;

  always_comb begin
    cmd_idx   = cmd_q[IDX_HI:IDX_LO];
    accept    = cmd_q[TOG_BIT] != tog_ref;
    is_commit = cmd_idx == COMMIT_INDEX;
    wr_body   = accept && !is_commit && !pend_q;
    swap      = frame_start && pend_q;
    cmd_entry = decode_entry(cmd_q);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cmd_q     <= '0;
      tog_ref   <= 1'b0;
      front_sel <= 1'b0;
      sel_q     <= 1'b0;
      pend_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      cmd_q <= cmd_word;
      // Output mux follows the bank that was read last edge
      sel_q <= front_sel;
      if (accept)
        tog_ref <= cmd_q[TOG_BIT];
      if (swap) begin
        front_sel <= ~front_sel;
        pend_q    <= 1'b0;
      end else if (accept && is_commit) begin
        pend_q <= 1'b1;
      end
      if (accept && !is_commit && pend_q)
        ovf_q <= 1'b1;
    end
  end

  body_bank u_bank0 (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .we    (wr_body && front_sel),
    .waddr (cmd_idx),
    .wdata (cmd_entry),
    .raddr (rd_index),
    .rdata (rd0)
  );

  body_bank u_bank1 (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .we    (wr_body && !front_sel),
    .waddr (cmd_idx),
    .wdata (cmd_entry),
    .raddr (rd_index),
    .rdata (rd1)
  );

  always_comb begin
    rd_e      = sel_q ? rd1 : rd0;
    rd_x      = rd_e.x;
    rd_y      = rd_e.y;
    rd_radius = rd_e.radius;
    rd_colour = rd_e.colour;
    // Reserved index reads back as zero, so radius alone decides
    rd_valid  = rd_e.radius != 4'd0;
  end

  assign commit_pending = pend_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_body_table.sv
// Self-checking bench for body_table against a table-level model.
// Model keeps a front and back table of {x,y,r,c} and swaps them whole.
module tb_body_table;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [31:0] cmd_word;
  logic        frame_start;
  logic [3:0]  rd_index;
  logic [9:0]  rd_x;
  logic [8:0]  rd_y;
  logic [3:0]  rd_radius;
  logic [3:0]  rd_colour;
  logic        rd_valid;
  logic        commit_pending;
  logic        overflow;

  body_table dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .cmd_word       (cmd_word),
    .frame_start    (frame_start),
    .rd_index       (rd_index),
    .rd_x           (rd_x),
    .rd_y           (rd_y),
    .rd_radius      (rd_radius),
    .rd_colour      (rd_colour),
    .rd_valid       (rd_valid),
    .commit_pending (commit_pending),
    .overflow       (overflow)
  );

  always #5 clk_clk = ~clk_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // entry layout: {x[26:17], y[16:8], r[7:4], c[3:0]}
  logic [26:0] m_front [15];
  logic [26:0] m_back  [15];
  bit          m_tog;
  bit          m_pend;
  bit          m_ovf;
  bit          sw_tog;

  function automatic logic [26:0] ent(
    input logic [9:0] x, input logic [8:0] y,
    input logic [3:0] r, input logic [3:0] c
  );
    return {x, y, r, c};
  endfunction

  function automatic logic [26:0] rnd_ent();
    return ent(10'($urandom), 9'($urandom),
               4'($urandom), 4'($urandom));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) begin
      m_front[i] = '0;
      m_back[i]  = '0;
    end
    m_tog  = 0;
    m_pend = 0;
    m_ovf  = 0;
    sw_tog = 0;
  endtask

  task automatic model_word(input bit t, input logic [3:0] idx,
                            input logic [26:0] e);
    if (t == m_tog) return;
    m_tog = t;
    if (idx == 4'hF) m_pend = 1;
    else if (m_pend) m_ovf = 1;
    else m_back[idx] = e;
  endtask

  task automatic model_frame();
    logic [26:0] tmp [15];
    if (!m_pend) return;
    tmp     = m_front;
    m_front = m_back;
    m_back  = tmp;
    m_pend  = 0;
  endtask

  function automatic logic [31:0] mk(input bit t, input logic [3:0] idx,
                                     input logic [26:0] e);
    return {t, idx, e[16:8], e[26:17], e[7:4], e[3:0]};
  endfunction

  task automatic drive(input bit t, input logic [3:0] idx,
                       input logic [26:0] e);
    cmd_word = mk(t, idx, e);
    repeat (3) @(posedge clk_clk);
    #1;
    model_word(t, idx, e);
  endtask

  task automatic send_body(input logic [3:0] idx, input logic [26:0] e);
    sw_tog = ~sw_tog;
    drive(sw_tog, idx, e);
  endtask

  task automatic send_commit();
    sw_tog = ~sw_tog;
    drive(sw_tog, 4'hF, 27'd0);
  endtask

  task automatic pulse_frame();
    frame_start = 1;
    @(posedge clk_clk);
    #1;
    frame_start = 0;
    model_frame();
  endtask

  task automatic check_read(input logic [3:0] idx, input string tag);
    logic [26:0] exp, got;
    bit          expv;
    rd_index = idx;
    @(posedge clk_clk);
    #1;
    exp  = (idx < 15) ? m_front[idx] : 27'd0;
    expv = (idx < 15) && (exp[7:4] != 0);
    got  = {rd_x, rd_y, rd_radius, rd_colour};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s data idx=%0d got=%h want=%h", tag, idx, got, exp);
    end
    n_cmp++;
    if (rd_valid !== expv) begin
      n_bad++;
      $display("FAIL %s valid idx=%0d got=%b want=%b", tag, idx,
               rd_valid, expv);
    end
  endtask

  task automatic check_flags(input string tag);
    n_cmp++;
    if (commit_pending !== m_pend) begin
      n_bad++;
      $display("FAIL %s pending got=%b want=%b", tag, commit_pending,
               m_pend);
    end
    n_cmp++;
    if (overflow !== m_ovf) begin
      n_bad++;
      $display("FAIL %s overflow got=%b want=%b", tag, overflow, m_ovf);
    end
  endtask

  task automatic test_reset();
    reset_reset_n = 0;
    cmd_word      = '0;
    #2;
    model_reset();
    n_cmp++;
    if ({rd_x, rd_y, rd_radius, rd_colour, rd_valid} !== 28'd0) begin
      n_bad++;
      $display("FAIL reset_rd got=%h want=0",
               {rd_x, rd_y, rd_radius, rd_colour, rd_valid});
    end
    check_flags("reset");
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1;
    @(posedge clk_clk);
    #1;
    check_read(4'd3, "reset_idx3");
    check_flags("reset_after");
  endtask

  task automatic test_write_commit_swap();
    logic [26:0] e;
    e = ent(10'd320, 9'd240, 4'd5, 4'd9);
    send_body(4'd2, e);
    send_commit();
    check_flags("wcs_pend");
    rd_index = 4'd2;
    @(posedge clk_clk);
    #1;
    n_cmp++;
    if ({rd_x, rd_y, rd_radius, rd_colour, rd_valid} !== 28'd0) begin
      n_bad++;
      $display("FAIL wcs_before got=%h want=0",
               {rd_x, rd_y, rd_radius, rd_colour, rd_valid});
    end
    pulse_frame();
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wcs_one_cycle valid got=%b want=0", rd_valid);
    end
    @(posedge clk_clk);
    #1;
    n_cmp++;
    if ({rd_x, rd_y, rd_radius, rd_colour, rd_valid} !== {e, 1'b1}) begin
      n_bad++;
      $display("FAIL wcs_two_cycle got=%h want=%h",
               {rd_x, rd_y, rd_radius, rd_colour, rd_valid}, {e, 1'b1});
    end
    check_flags("wcs_swapped");
  endtask

  task automatic test_unflipped();
    logic [26:0] e1, e2;
    e1 = ent(10'd100, 9'd50, 4'd3, 4'd1);
    e2 = ent(10'd600, 9'd400, 4'd7, 4'd2);
    send_body(4'd4, e1);
    repeat (10) @(posedge clk_clk);
    #1;
    drive(sw_tog, 4'd4, e2);
    send_commit();
    pulse_frame();
    check_read(4'd4, "unflipped");
  endtask

  task automatic test_pending_write();
    send_commit();
    send_body(4'd1, ent(10'd7, 9'd8, 4'd9, 4'd10));
    check_flags("pw_dropped");
    pulse_frame();
    check_read(4'd1, "pw_entry1");
    check_flags("pw_after_swap");
  endtask

  task automatic test_coincident();
    pulse_frame();
    sw_tog   = ~sw_tog;
    cmd_word = mk(sw_tog, 4'hF, 27'd0);
    @(posedge clk_clk);
    #1;
    frame_start = 1;
    @(posedge clk_clk);
    #1;
    frame_start = 0;
    model_word(sw_tog, 4'hF, 27'd0);
    check_flags("coin_pending");
    check_read(4'd2, "coin_noswap");
    pulse_frame();
    check_flags("coin_swapped");
    check_read(4'd2, "coin_read");
  endtask

  task automatic test_reserved_disabled();
    send_body(4'd6, ent(10'd1023, 9'd511, 4'd0, 4'd15));
    send_body(4'd14, rnd_ent());
    send_commit();
    pulse_frame();
    check_read(4'd15, "reserved");
    check_read(4'd6, "disabled");
    check_read(4'd14, "last_body");
  endtask

  task automatic test_random();
    for (int k = 0; k < 120; k++) begin
      case ($urandom_range(9))
        0, 1, 2, 3, 4:
          send_body(4'($urandom_range(14)), rnd_ent());
        5: drive(sw_tog, 4'($urandom_range(15)), rnd_ent());
        6: send_commit();
        7: pulse_frame();
        default: check_read(4'($urandom_range(15)), "rand_read");
      endcase
      if (k % 10 == 0) check_flags("rand_flags");
    end
    send_commit();
    pulse_frame();
    for (int i = 0; i < 16; i++) check_read(4'(i), "rand_sweep");
  endtask

  task automatic test_reset_mid();
    send_body(4'd2, rnd_ent());
    send_commit();
    send_body(4'd3, rnd_ent());
    test_reset();
    check_read(4'd2, "mid_idx2");
    send_body(4'd5, ent(10'd11, 9'd22, 4'd1, 4'd3));
    send_commit();
    pulse_frame();
    check_read(4'd5, "post_reset_write");
    check_flags("post_reset_flags");
  endtask

  initial begin
    frame_start = 0;
    rd_index    = '0;
    cmd_word    = '0;
    test_reset();
    test_write_commit_swap();
    test_unflipped();
    test_pending_write();
    test_coincident();
    test_reserved_disabled();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule

// File: doc/body_table.md
# body_table

Double-buffered body-attribute table sitting directly downstream of the Nios system's 32-bit `avalon_interface_export_data_new_signal` conduit. Software writes one packed command word per body (position, radius, colour) and then a commit word. The block decodes each new word and stores it in the back bank. At the next frame start it swaps banks, so the VGA renderer always reads a complete, tear-free set of body positions through a one-cycle-latency read port.

## Interface
- `NUM_BODIES`, 15: number of body entries; index 15 is reserved as the commit command.
- `X_W`, 10: x coordinate width (0..639).
- `Y_W`, 9: y coordinate width (0..479).
- `clk_clk` input 1: system clock, same clock as the Nios system.
- `reset_reset_n` input 1: asynchronous, active-low reset.
- `cmd_word` input 32: the Nios export conduit.
  - [31] toggle
  - [30:27] index
  - [26:18] y
  - [17:8] x
  - [7:4] radius
  - [3:0] colour
- `frame_start` input 1: single-cycle pulse from the VGA controller at the start of vertical blanking.
- `rd_index` input 4: body index requested by the renderer.
- `rd_x` output 10: x of `rd_index` from the front bank.
- `rd_y` output 9: y of `rd_index` from the front bank.
- `rd_radius` output 4: radius from the front bank; 0 means the body is disabled.
- `rd_colour` output 4: colour from the front bank.
- `rd_valid` output 1: high when `rd_index` < `NUM_BODIES` and radius ≠ 0.
- `commit_pending` output 1: a commit has been received and the swap has not yet occurred.
- `overflow` output 1: sticky; a body write was dropped while `commit_pending` was high.

## Operation
- **Capture.** `cmd_word` is registered every cycle into `cmd_q`. `tog_ref` holds the toggle bit of the last accepted word.
- **Acceptance.** A new command is accepted when `cmd_q[31]` ≠ `tog_ref`. On acceptance, `tog_ref` ← `cmd_q[31]`. Steady words and repeated identical words without a toggle flip are ignored.
- **Body write** (index 0..14, `commit_pending` = 0): write {x, y, radius, colour} to entry[index] of the back bank (bank ≠ `front_sel`).
- **Body write while pending** (`commit_pending` = 1): the write is dropped and `overflow` is set. `tog_ref` still updates.
- **Commit** (index 15): set `commit_pending`. A second commit while already pending is ignored with no `overflow`.
- **Swap.** On `frame_start` with `commit_pending` = 1, `front_sel` toggles and `commit_pending` clears. On `frame_start` with `commit_pending` = 0, nothing happens.
- **Bank contents after swap.** The new back bank holds the contents from two frames ago. Software rewrites every active body before each commit; no copy-forward is performed.
- **Read port.** `rd_*` are registered from the front bank entry at `rd_index`. `rd_index` = 15 returns all zeros with `rd_valid` = 0.
- **Arithmetic.** No arithmetic is performed. Fields are stored as-is; out-of-screen coordinates are stored unclipped and clipping belongs to the renderer.
- **Reset values.**
  - Both banks, `cmd_q`, `tog_ref`, `front_sel`, `commit_pending` and `overflow` are 0.
  - All `rd_*` outputs are 0.
  - `overflow` is cleared only by reset.
- **Reset mid-operation.** A pending commit is discarded, the banks are cleared, and `tog_ref` returns to 0. Software must next send a word with toggle = 1.

## Timing
- Command latency:
  - `cmd_word` changes at edge N.
  - `cmd_q` is valid after edge N+1.
  - The entry write or `commit_pending` set takes effect at edge N+2.
- Swap latency:
  - `frame_start` is sampled high at edge F, and `front_sel` flips at edge F.
  - `rd_*` reflect the new bank after edge F+1.
- Read latency: `rd_index` is sampled at edge R, and `rd_*` are valid after edge R (1 cycle).
- **Commit accepted in the same cycle as `frame_start`.** No swap occurs this frame; `commit_pending` sets and the swap happens at the next `frame_start`.
- **Body write accepted in the same cycle as a swap** (only possible when pending = 0, i.e. no swap): the write proceeds normally.
- Software must hold each word for ≥ 2 clock cycles. A Nios PIO write satisfies this trivially.

## Structure
- `body_pkg` package contains:
  - `body_entry_t` struct: {x[9:0], y[8:0], radius[3:0], colour[3:0]}, 27 bits.
  - Field bit-position constants for the command word.
  - `COMMIT_INDEX` = 4'hF.
- One sub-module, `body_bank`: a 15-entry `body_entry_t` register file with one write port and one registered read port, instantiated twice.
- Top-level `body_table` owns the capture register, toggle detection, pending/overflow flags, bank-select and the output mux.

## Test plan
- **Reset.** Assert `reset_reset_n` = 0 mid-stream → all `rd_*` = 0, `commit_pending` = 0, `overflow` = 0; `rd_index` = 3 reads 0 with `rd_valid` = 0.
- **Write, commit, swap.** Write body 2 (x = 320, y = 240, r = 5, c = 9, toggle = 1), commit (toggle = 0), pulse `frame_start` → `rd_index` = 2 gives 320/240/5/9 with `rd_valid` = 1 exactly 2 cycles after the pulse edge. Before the pulse, the same read returns 0.
- **Unflipped toggle.** Hold body 4 word with toggle unchanged for 10 cycles, then change its payload without flipping toggle → after commit + swap, only the first payload is stored.
- **Write while pending.** Commit, then write body 1 before `frame_start` → write is dropped, `overflow` = 1. After swap, entry 1 still holds its previous value; `overflow` stays 1.
- **Commit coincident with frame_start.** Commit accepted in the same cycle as `frame_start` → no swap; `commit_pending` = 1. The next `frame_start` swaps and clears pending.
- **Reserved index and disabled body.** `rd_index` = 15 → all zeros, `rd_valid` = 0. A body written with radius = 0 → `rd_valid` = 0 while x/y are still readable.
